// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 3;
    localparam int ROUTER_ADDR_W    = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } ctrl_state_t;

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for WAIT_TILL_EMPTY; held at zero outside the wait state,
// flags expiry once WAIT_LIMIT cycles have been counted.
module router_wait_timer #(
    parameter int WAIT_LIMIT = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic in_wait,
    output logic expired
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [CNT_W-1:0] count;

    // The FSM always leaves the wait state at expiry, so no saturation is needed.
    always_ff @(posedge clock) begin
        if (reset || !in_wait) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = in_wait && (count == CNT_W'(WAIT_LIMIT));

endmodule

// File: rtl/router_pkt_ctrl.sv
// Packet-sequencing FSM for the 1x3 router: header decode, FIFO flow control
// and Moore state strobes. Optional wait timeout: ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN.
import router_pkg::*;

module router_pkt_ctrl #(
    parameter int NUM_PORTS  = ROUTER_NUM_PORTS,
    parameter int ADDR_W     = ROUTER_ADDR_W,
    parameter int WAIT_LIMIT = 1023
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 full_state,
    output logic                 laf_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic                 timeout
);

    localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

    ctrl_state_t       state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic              addr_legal;
    logic              hdr_empty;
    logic              cur_empty;
    logic              cur_soft;
    logic              wait_expired;

    assign addr_legal = ({1'b0, data_in} < PORT_LIMIT);
    assign hdr_empty  = addr_legal && fifo_empty[data_in];
    assign cur_empty  = fifo_empty[addr_q];
    assign cur_soft   = soft_reset[addr_q];

`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
    logic timeout_d;
    logic timeout_q;

    router_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .in_wait (state == WAIT_TILL_EMPTY),
        .expired (wait_expired)
    );

    // Pulse only when expiry actually drives the exit; a draining FIFO or a
    // soft reset on the same cycle takes precedence.
    assign timeout_d = wait_expired && !cur_empty && !cur_soft;

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_wait_limit;

    assign unused_wait_limit = |WAIT_LIMIT;
    assign wait_expired      = 1'b0;
    assign timeout           = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid && addr_legal) begin
                addr_q <= data_in;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && addr_legal) begin
                    next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (cur_empty) begin
                    next_state = LOAD_FIRST_DATA;
                end else if (wait_expired) begin
                    next_state = DECODE_ADDRESS;
                end
            end
            default: next_state = DECODE_ADDRESS;
        endcase

        // Read-timeout on the FIFO this packet targets aborts the packet.
        if (state != DECODE_ADDRESS && cur_soft) begin
            next_state = DECODE_ADDRESS;
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: lfd_state = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            FIFO_FULL_STATE: full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY:        write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
            WAIT_TILL_EMPTY:    busy          = 1'b1;
            default: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Scoreboard bench for router_pkt_ctrl: per-cycle stimulus rows carry the
// expected output vector, queued on drive and compared after the edge.
module tb_router_pkt_ctrl;

    // {detect_add, lfd, ld, full, laf, rst_int, write_enb, busy, timeout}
    localparam logic [8:0] S_DA  = 9'b1_0000_0_0_0_0;
    localparam logic [8:0] S_LFD = 9'b0_1000_0_0_1_0;
    localparam logic [8:0] S_LD  = 9'b0_0100_0_1_0_0;
    localparam logic [8:0] S_FFS = 9'b0_0010_0_0_1_0;
    localparam logic [8:0] S_LAF = 9'b0_0001_0_1_1_0;
    localparam logic [8:0] S_LP  = 9'b0_0000_0_1_1_0;
    localparam logic [8:0] S_CPE = 9'b0_0000_1_0_1_0;
    localparam logic [8:0] S_WTE = 9'b0_0000_0_0_1_0;
    localparam logic [8:0] S_DTO = 9'b1_0000_0_0_0_1;

    typedef struct {
        logic       rst;
        logic       pv;
        logic [1:0] d;
        logic       full;
        logic [2:0] e;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [8:0] exp;
    } row_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, write_enb_reg, busy, timeout;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    router_pkt_ctrl #(
        .NUM_PORTS  (3),
        .ADDR_W     (2),
        .WAIT_LIMIT (15)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .full_state    (full_state),
        .laf_state     (laf_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clock = ~clock;

    assign outs = {detect_add, lfd_state, ld_state, full_state, laf_state,
                   rst_int_reg, write_enb_reg, busy, timeout};

    function automatic row_t mk(input logic rst, input logic pv, input logic [1:0] d,
                                input logic full, input logic [2:0] e, input logic [2:0] sr,
                                input logic pd, input logic lpv, input logic [8:0] exp);
        row_t r;
        r.rst = rst; r.pv = pv; r.d = d; r.full = full; r.e = e;
        r.sr = sr; r.pd = pd; r.lpv = lpv; r.exp = exp;
        return r;
    endfunction

    task automatic drive(input row_t r);
        reset         = r.rst;
        pkt_valid     = r.pv;
        data_in       = r.d;
        fifo_full     = r.full;
        fifo_empty    = r.e;
        soft_reset    = r.sr;
        parity_done   = r.pd;
        low_pkt_valid = r.lpv;
        exp_q.push_back(r.exp);
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [8:0] exp;
        rows.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, S_DA));
        rows.push_back(mk(1, 1, 1, 1, 3'b000, 3'b111, 1, 1, S_DA));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_DA));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL reset[%0d] got=%b exp=%b", i, outs, exp);
            end
        end
    endtask

    task automatic test_header_payload();
        row_t rows[$];
        logic [8:0] exp;
        rows.push_back(mk(0, 1, 1, 0, 3'b111, 0, 0, 0, S_LFD));
        rows.push_back(mk(0, 1, 2, 0, 3'b111, 0, 0, 0, S_LD));
        rows.push_back(mk(0, 1, 3, 0, 3'b111, 0, 0, 0, S_LD));
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, S_LD));
        rows.push_back(mk(0, 1, 1, 0, 3'b111, 0, 0, 0, S_LD));
        rows.push_back(mk(0, 0, 2, 0, 3'b111, 0, 0, 0, S_LP));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_CPE));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_DA));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL header_payload[%0d] got=%b exp=%b", i, outs, exp);
            end
        end
    endtask

    task automatic test_fifo_full();
        row_t rows[$];
        logic [8:0] exp;
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, S_LFD));
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, S_LD));
        // full wins over the simultaneous pkt_valid drop
        rows.push_back(mk(0, 0, 0, 1, 3'b111, 0, 0, 0, S_FFS));
        for (int k = 0; k < 4; k++) rows.push_back(mk(0, 0, 0, 1, 3'b111, 0, 0, 0, S_FFS));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_LAF));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 1, S_LP));
        rows.push_back(mk(0, 0, 0, 1, 3'b111, 0, 0, 0, S_CPE));
        rows.push_back(mk(0, 0, 0, 1, 3'b111, 0, 0, 0, S_FFS));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_LAF));
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, S_LD));
        rows.push_back(mk(0, 1, 0, 1, 3'b111, 0, 0, 0, S_FFS));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_LAF));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 1, 1, S_DA));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL fifo_full[%0d] got=%b exp=%b", i, outs, exp);
            end
        end
    endtask

    task automatic test_wait_and_bad_addr();
        row_t rows[$];
        logic [8:0] exp;
        rows.push_back(mk(0, 1, 2, 0, 3'b011, 0, 0, 0, S_WTE));
        for (int k = 0; k < 6; k++) rows.push_back(mk(0, 1, 0, 0, 3'b011, 0, 0, 0, S_WTE));
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, S_LFD));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_LD));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_LP));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_CPE));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_DA));
        rows.push_back(mk(0, 1, 3, 0, 3'b111, 0, 0, 0, S_DA));
        rows.push_back(mk(0, 1, 3, 0, 3'b000, 0, 0, 0, S_DA));
        rows.push_back(mk(0, 0, 1, 0, 3'b111, 0, 0, 0, S_DA));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL wait_bad_addr[%0d] got=%b exp=%b", i, outs, exp);
            end
        end
    endtask

    task automatic test_soft_reset();
        row_t rows[$];
        logic [8:0] exp;
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, S_LFD));
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, S_LD));
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 3'b010, 0, 0, S_LD));
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 3'b001, 0, 0, S_DA));
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, S_LFD));
        rows.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, S_LD));
        rows.push_back(mk(0, 1, 0, 1, 3'b111, 0, 0, 0, S_FFS));
        rows.push_back(mk(1, 1, 0, 1, 3'b111, 0, 0, 0, S_DA));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_DA));
        // addr_q cleared by reset: soft_reset[0] must abort a wait on port 0
        rows.push_back(mk(0, 1, 0, 0, 3'b110, 0, 0, 0, S_WTE));
        rows.push_back(mk(0, 0, 0, 0, 3'b110, 3'b110, 0, 0, S_WTE));
        rows.push_back(mk(0, 0, 0, 0, 3'b110, 3'b001, 0, 0, S_DA));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL soft_reset[%0d] got=%b exp=%b", i, outs, exp);
            end
        end
    endtask

    task automatic test_wait_timeout();
        row_t rows[$];
        logic [8:0] exp;
        rows.push_back(mk(0, 1, 0, 0, 3'b110, 0, 0, 0, S_WTE));
        for (int k = 0; k < 15; k++) rows.push_back(mk(0, 0, 0, 0, 3'b110, 0, 0, 0, S_WTE));
`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
        rows.push_back(mk(0, 0, 0, 0, 3'b110, 0, 0, 0, S_DTO));
        rows.push_back(mk(0, 0, 0, 0, 3'b110, 0, 0, 0, S_DA));
        // empty on the expiry cycle: LFD wins, no pulse
        rows.push_back(mk(0, 1, 0, 0, 3'b110, 0, 0, 0, S_WTE));
        for (int k = 0; k < 15; k++) rows.push_back(mk(0, 0, 0, 0, 3'b110, 0, 0, 0, S_WTE));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_LFD));
        rows.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, S_LD));
`else
        for (int k = 0; k < 4; k++) rows.push_back(mk(0, 0, 0, 0, 3'b110, 0, 0, 0, S_WTE));
`endif
        rows.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, S_DA));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL wait_timeout[%0d] got=%b exp=%b", i, outs, exp);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        pkt_valid     = 1'b0;
        data_in       = '0;
        fifo_full     = 1'b0;
        fifo_empty    = 3'b111;
        soft_reset    = '0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        @(posedge clock); #1;
        test_reset();
        test_header_payload();
        test_fifo_full();
        test_wait_and_bad_addr();
        test_soft_reset();
        test_wait_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
